// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx - 8-bit UART receiver with an internal receive FIFO.
//
// Receives 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) from an
// asynchronous serial line. The line is synchronised with two flops. Each bit
// is sampled at mid-bit, and good bytes are pushed into a small FIFO that the
// bus side reads.
//
// Optional feature macro: UART_RX_PARITY_EN
//   Defined     : even-parity bit between data and stop, plus parity_err_o.
//   Not defined : plain 8N1 receiver, no parity port.
//
// Ports
//   clk_i        in   system clock, rising edge
//   rst_i        in   synchronous active-high reset
//   baud_div_i   in   clocks per bit (>= 4, change only while idle)
//   rx_en_i      in   receiver enable (checked only while idle)
//   rx_re_i      in   FIFO read strobe, one byte per high cycle
//   err_clr_i    in   clears the sticky error flags
//   rx_bit_i     in   asynchronous serial line, idle high
//   dout_o       out  FIFO read data (valid the cycle after a pop)
//   empty_o      out  receive FIFO empty
//   full_o       out  receive FIFO full
//   frame_err_o  out  sticky: stop bit sampled low
//   overrun_o    out  sticky: byte dropped because FIFO full
//   parity_err_o out  sticky: parity mismatch (only with UART_RX_PARITY_EN)
//   busy_o       out  frame in progress
//   dbg_state_o  out  current receiver state, for debug/checkers
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           baud_div_i,
    input  logic                  rx_en_i,
    input  logic                  rx_re_i,
    input  logic                  err_clr_i,
    input  logic                  rx_bit_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err_o,
`endif
    output logic                  busy_o,
    output logic [2:0]            dbg_state_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic [15:0]           r_baud_cnt;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  r_push;
    logic [DATA_WIDTH-1:0] r_push_data;
    logic                  r_frame_err;
    logic                  r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                  r_par_err;
    logic                  r_par_bad;
`endif

    logic                  w_rx_s;
    logic [15:0]           w_limit_m1;
    logic                  w_at_limit;

    assign w_rx_s = r_sync[1];

    // START waits half a bit so that all later samples land mid-bit.
    always_comb begin
        w_limit_m1 = baud_div_i - 16'd1;
        if (r_state == S_START) begin
            w_limit_m1 = (baud_div_i >> 1) - 16'd1;
        end
    end

    assign w_at_limit = (r_baud_cnt == w_limit_m1);

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_sync      <= 2'b11;
            r_baud_cnt  <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
            r_par_bad   <= 1'b0;
`endif
        end else begin
            r_sync <= {r_sync[0], rx_bit_i};
            r_push <= 1'b0;

            // Clear first; a set later in this block overrides (set wins).
            if (err_clr_i) begin
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_par_err   <= 1'b0;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= 16'd0;
                    if (rx_en_i && !w_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_at_limit) begin
                        r_baud_cnt <= 16'd0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;      // line back high: glitch
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_at_limit) begin
                        r_baud_cnt <= 16'd0;
                        // LSB arrives first, so shift in from the top.
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_at_limit) begin
                        r_baud_cnt <= 16'd0;
                        r_par_bad  <= (w_rx_s != (^r_shift));
                        r_state    <= S_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_at_limit) begin
                        r_baud_cnt <= 16'd0;
                        r_state    <= S_IDLE;
                        if (!w_rx_s) begin
                            r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            r_par_err <= 1'b1;
`endif
                        end else if (full_o) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_push      <= 1'b1;
                            r_push_data <= DATA_WIDTH'(r_shift);
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= 16'd0;
                end
            endcase
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign dbg_state_o = r_state;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = r_par_err;
`endif

    // --------------------------------------------------------------- FIFO ---
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_pop;

    // Overrun is decided at the stop sample, so a push never finds it full.
    assign w_pop   = rx_re_i && (r_count != '0);
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CW'(FIFO_DEPTH));
    assign dout_o  = r_dout;

    always_ff @(posedge clk_i) begin
        if (r_push) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (r_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({r_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx - self-checking bench for uart_rx (FIFO_DEPTH = 4, baud_div 16).
// Bytes expected to reach the FIFO are queued when their frame is driven and
// popped when the bench reads the FIFO.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'(BAUD);
    logic        rx_en = 1'b1;
    logic        rx_re = 1'b0;
    logic        err_clr = 1'b0;
    logic        rx_bit = 1'b1;
    logic [7:0]  dout;
    logic        empty, full, frame_err, overrun, busy;
    logic [2:0]  dbg_state;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_dout = 8'h00;

    uart_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .baud_div_i  (baud_div),
        .rx_en_i     (rx_en),
        .rx_re_i     (rx_re),
        .err_clr_i   (err_clr),
        .rx_bit_i    (rx_bit),
        .dout_o      (dout),
        .empty_o     (empty),
        .full_o      (full),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .busy_o      (busy),
        .dbg_state_o (dbg_state)
    );

    // ---- clock / reset -------------------------------------------------
    always #5 clk = ~clk;

    // ---- checker ---------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---- drivers (all start and end on a falling edge) ---------------------
    task automatic hold(input logic v, input int n);
        rx_bit = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
        hold(1'b0, BAUD);
        for (int i = 0; i < 8; i++) hold(b[i], BAUD);
`ifdef UART_RX_PARITY_EN
        hold(par_b, BAUD);
`else
        if (par_b) rx_bit = 1'b1;   // no parity bit in 8N1
`endif
        hold(stop_b, BAUD);
        rx_bit = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_bit = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Pop one byte and compare against the scoreboard head.
    task automatic read_byte(input string tag);
        int k;
        k = 0;
        while (empty && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (empty) begin
            check({tag, "_timeout"}, empty, 0);
        end else begin
            rx_re = 1'b1;
            @(negedge clk);
            rx_re = 1'b0;
            if (exp_q.size() > 0) begin
                last_dout = exp_q.pop_front();
                check(tag, dout, last_dout);
            end else begin
                check({tag, "_unexpected"}, dout, 32'hFFFF_FFFF);
            end
        end
    endtask

    // ---- test sequence ------------------------------------------------------
    initial begin
        int          lat;
        logic        busy_seen;
        logic [7:0]  b;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);
        check("rst_state", dbg_state, 0);
        idle(5);

        // 8N1 byte 0xA5 with latency measurement from the start edge
        lat = 0;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                for (int k = 1; k <= 300; k++) begin
                    @(negedge clk);
                    if (!empty) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        check("a5_latency", lat, 1 + 152 + 3);
        idle(10);
        check("a5_frame_err", frame_err, 0);
        check("a5_overrun", overrun, 0);
        read_byte("a5_data");
        check("a5_empty_after", empty, 1);

        // Read strobe on an empty FIFO is ignored
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
        @(negedge clk);
        check("empty_read_empty", empty, 1);
        check("empty_read_dout", dout, last_dout);

        // Glitch: 5 clocks low
        busy_seen = 1'b0;
        fork
            begin
                hold(1'b0, 5);
                idle(40);
            end
            begin
                for (int k = 0; k < 45; k++) begin
                    @(negedge clk);
                    if (busy) busy_seen = 1'b1;
                end
            end
        join
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_end", busy, 0);
        check("glitch_empty", empty, 1);
        check("glitch_frame_err", frame_err, 0);

        // Framing error: 0x3C with stop bit low
        send_frame(8'h3C, 1'b0, ^8'h3C);
        idle(3 * BAUD);
        check("ferr_flag", frame_err, 1);
        check("ferr_empty", empty, 1);
        clear_errors();
        check("ferr_cleared", frame_err, 0);

        // Overrun: 5 back-to-back frames into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            if (i <= 4) exp_q.push_back(b);
            send_frame(b, 1'b1, ^b);
        end
        idle(2 * BAUD);
        check("ovr_full", full, 1);
        check("ovr_flag", overrun, 1);
        check("ovr_frame_err", frame_err, 0);
        for (int i = 0; i < 4; i++) read_byte("ovr_data");
        check("ovr_empty", empty, 1);
        check("ovr_not_full", full, 0);
        clear_errors();
        check("ovr_cleared", overrun, 0);

        // Reset during bit 3 of 0xFF, then 0x5A
        fork
            send_frame(8'hFF, 1'b1, ^8'hFF);
            begin
                repeat (BAUD + 3 * BAUD + BAUD / 2) @(negedge clk);
                check("midrst_busy", busy, 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("midrst_idle", busy, 0);
            end
        join
        idle(BAUD);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(BAUD);
        read_byte("midrst_data");
        check("midrst_empty", empty, 1);
        check("midrst_flags", {frame_err, overrun}, 0);

        // Random bytes, each read back in turn
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, ^b);
            idle($urandom_range(0, 20));
            read_byte("rand_data");
        end

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has odd weight, so even parity bit is 1
        check("par_rst", parity_err, 0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(BAUD);
        read_byte("par_good_data");
        check("par_good_flag", parity_err, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2 * BAUD);
        check("par_bad_flag", parity_err, 1);
        check("par_bad_empty", empty, 1);
        clear_errors();
        check("par_cleared", parity_err, 0);
`endif

        check("sb_leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL timeout: simulation exceeded cycle budget");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
